// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
//   Data-side memory bus between the core's initiator and a memory responder.
//   Request fields (initiator -> responder):
//     mem_d_addr_w        32  request byte address
//     mem_d_data_wr_w     32  store data
//     mem_d_rd_w           1  load request
//     mem_d_wr_w           4  store byte strobes, bit n writes byte n
//     mem_d_cacheable_w    1  cacheable hint
//     mem_d_req_tag_w     11  request tag
//     mem_d_invalidate_w   1  cache-invalidate op
//     mem_d_writeback_w    1  cache-writeback op
//     mem_d_flush_w        1  cache-flush op
//   Response fields (responder -> initiator):
//     mem_d_accept_w       1  responder takes a request this cycle
//     mem_d_ack_w          1  response valid
//     mem_d_data_rd_w     32  load data
//     mem_d_error_w        1  response carries an error
//     mem_d_resp_tag_w    11  tag of the response
//   Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface dmem_if;
    logic [31:0] mem_d_addr_w;
    logic [31:0] mem_d_data_wr_w;
    logic        mem_d_rd_w;
    logic [3:0]  mem_d_wr_w;
    logic        mem_d_cacheable_w;
    logic [10:0] mem_d_req_tag_w;
    logic        mem_d_invalidate_w;
    logic        mem_d_writeback_w;
    logic        mem_d_flush_w;
    logic        mem_d_accept_w;
    logic        mem_d_ack_w;
    logic [31:0] mem_d_data_rd_w;
    logic        mem_d_error_w;
    logic [10:0] mem_d_resp_tag_w;

    modport master (
        output mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
               mem_d_cacheable_w, mem_d_req_tag_w, mem_d_invalidate_w,
               mem_d_writeback_w, mem_d_flush_w,
        input  mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w,
               mem_d_error_w, mem_d_resp_tag_w
    );

    modport slave (
        input  mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
               mem_d_cacheable_w, mem_d_req_tag_w, mem_d_invalidate_w,
               mem_d_writeback_w, mem_d_flush_w,
        output mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w,
               mem_d_error_w, mem_d_resp_tag_w
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Slave end of the core's data memory port. Holds a word-addressed RAM of
//   2**ADDR_W 32-bit words starting at byte address BASE_ADDR, accepts load,
//   store and cache-maintenance requests, and returns in-order responses a
//   fixed LATENCY (1..8) cycles after the accept edge.
//
//   Ports:
//     clk    clock, all logic on the rising edge
//     rst    asynchronous active-low reset
//     mem_d  dmem_if.slave: request fields in, accept/ack/data/error/tag out
//
//   Optional feature (macro DMEM_STALL_INJECT_EN): a 16-bit LFSR deasserts
//   accept on roughly a quarter of the cycles to exercise initiator stalls.
//   Without the macro accept is 1 on every cycle after reset.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave mem_d
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

    // ---------------------------------------------------------------- accept
    logic accept_reg;

`ifdef DMEM_STALL_INJECT_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg   <= 16'hACE1;
            accept_reg <= 1'b0;
        end else begin
            lfsr_reg   <= {lfsr_reg[14:0], lfsr_fb};
            accept_reg <= ~(lfsr_reg[1] & lfsr_reg[0]);
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accept_reg <= 1'b0;
        end else begin
            accept_reg <= 1'b1;
        end
    end
`endif

    // ---------------------------------------------------------------- decode
    logic              wr_any;
    logic              mem_op;
    logic [2:0]        op_count;
    logic              req;
    logic              take;
    logic [31:0]       offset;
    logic              in_range;
    logic              misaligned;
    logic              req_err;
    logic              st_en;
    logic              ld_en;
    logic [ADDR_W-1:0] idx;
    logic              unused_cacheable;

    assign unused_cacheable = mem_d.mem_d_cacheable_w;

    assign wr_any   = |mem_d.mem_d_wr_w;
    assign mem_op   = mem_d.mem_d_rd_w | wr_any;
    assign op_count = {2'b00, mem_d.mem_d_rd_w} + {2'b00, wr_any}
                    + {2'b00, mem_d.mem_d_invalidate_w}
                    + {2'b00, mem_d.mem_d_writeback_w}
                    + {2'b00, mem_d.mem_d_flush_w};
    assign req      = (op_count != 3'd0);
    assign take     = req & accept_reg;

    // Subtraction wraps modulo 2**32, so addresses below BASE_ADDR land far
    // above SPAN and a single unsigned compare covers both bounds.
    assign offset     = mem_d.mem_d_addr_w - BASE_ADDR;
    assign in_range   = (offset < SPAN);
    assign misaligned = |mem_d.mem_d_addr_w[1:0];
    assign idx        = offset[ADDR_W+1:2];

    // More than one op at once covers the rd+wr combination as well.
    assign req_err = (mem_op && (!in_range || misaligned)) || (op_count > 3'd1);
    assign st_en   = take && wr_any && !req_err;
    assign ld_en   = take && mem_d.mem_d_rd_w && !req_err;

    // ------------------------------------------------------------------- RAM
    // Not reset: contents survive reset. Read is registered on the accept
    // edge; a store and a load are never taken on the same edge.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] ram_q_reg;

    always_ff @(posedge clk) begin
        if (take) begin
            ram_q_reg <= ram[idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (st_en && mem_d.mem_d_wr_w[b]) begin
                ram[idx][b*8 +: 8] <= mem_d.mem_d_data_wr_w[b*8 +: 8];
            end
        end
    end

    // -------------------------------------------------------- response pipe
    // Stage 0 is loaded on the accept edge; each later stage copies the one
    // before it, so stage LATENCY-1 presents the response LATENCY-1 edges on.
    logic        stage_valid [LATENCY];
    logic [10:0] stage_tag   [LATENCY];
    logic        stage_err   [LATENCY];
    logic [31:0] stage_data  [LATENCY];

    logic        valid0_reg;
    logic [10:0] tag0_reg;
    logic        err0_reg;
    logic        ld0_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0_reg <= 1'b0;
            tag0_reg   <= '0;
            err0_reg   <= 1'b0;
            ld0_reg    <= 1'b0;
        end else if (take) begin
            valid0_reg <= 1'b1;
            tag0_reg   <= mem_d.mem_d_req_tag_w;
            err0_reg   <= req_err;
            ld0_reg    <= ld_en;
        end else begin
            valid0_reg <= 1'b0;
            tag0_reg   <= '0;
            err0_reg   <= 1'b0;
            ld0_reg    <= 1'b0;
        end
    end

    // Gating the raw RAM output here keeps data at 0 for stores, maintenance
    // ops, errors and idle cycles all the way down the pipe.
    assign stage_valid[0] = valid0_reg;
    assign stage_tag[0]   = tag0_reg;
    assign stage_err[0]   = err0_reg;
    assign stage_data[0]  = ld0_reg ? ram_q_reg : 32'h0;

    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        logic        valid_reg;
        logic [10:0] tag_reg;
        logic        err_reg;
        logic [31:0] data_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_reg <= 1'b0;
                tag_reg   <= '0;
                err_reg   <= 1'b0;
                data_reg  <= '0;
            end else begin
                valid_reg <= stage_valid[gi-1];
                tag_reg   <= stage_tag[gi-1];
                err_reg   <= stage_err[gi-1];
                data_reg  <= stage_data[gi-1];
            end
        end

        assign stage_valid[gi] = valid_reg;
        assign stage_tag[gi]   = tag_reg;
        assign stage_err[gi]   = err_reg;
        assign stage_data[gi]  = data_reg;
    end

    // --------------------------------------------------------------- outputs
    assign mem_d.mem_d_accept_w   = accept_reg;
    assign mem_d.mem_d_ack_w      = stage_valid[LATENCY-1];
    assign mem_d.mem_d_resp_tag_w = stage_tag[LATENCY-1];
    assign mem_d.mem_d_error_w    = stage_err[LATENCY-1];
    assign mem_d.mem_d_data_rd_w  = stage_data[LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder (ADDR_W=12, BASE 8000_0000, LATENCY=2).
//   Requests are driven 1 ns after a rising edge and outputs are sampled on
//   the falling edge. A burst of n requests issues one request per cycle;
//   the response to request j is expected in burst cycle j+LAT and every
//   other cycle must show an idle (all-zero) response.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(
        .ADDR_W    (12),
        .BASE_ADDR (32'h8000_0000),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mem_d (bus)
    );

    // Burst tables
    logic        b_rd    [8];
    logic [3:0]  b_wr    [8];
    logic [31:0] b_addr  [8];
    logic [31:0] b_wdata [8];
    logic [10:0] b_tag   [8];
    logic [2:0]  b_maint [8];   // {invalidate, writeback, flush}
    logic [31:0] e_data  [8];
    logic        e_err   [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] maint);
        bus.mem_d_rd_w         = rd;
        bus.mem_d_wr_w         = wr;
        bus.mem_d_addr_w       = addr;
        bus.mem_d_data_wr_w    = wdata;
        bus.mem_d_req_tag_w    = tag;
        bus.mem_d_cacheable_w  = 1'b1;
        bus.mem_d_invalidate_w = maint[2];
        bus.mem_d_writeback_w  = maint[1];
        bus.mem_d_flush_w      = maint[0];
    endtask

    task automatic clr();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000);
        bus.mem_d_cacheable_w = 1'b0;
    endtask

    task automatic slot(input int i, input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [10:0] tag, input logic [2:0] maint,
                        input logic [31:0] edata, input logic eerr);
        b_rd[i] = rd; b_wr[i] = wr; b_addr[i] = addr; b_wdata[i] = wdata;
        b_tag[i] = tag; b_maint[i] = maint; e_data[i] = edata; e_err[i] = eerr;
    endtask

    task automatic expect_idle(input string name);
        chk({name, ".ack"},  32'(bus.mem_d_ack_w),      32'h0);
        chk({name, ".tag"},  32'(bus.mem_d_resp_tag_w), 32'h0);
        chk({name, ".data"}, bus.mem_d_data_rd_w,       32'h0);
        chk({name, ".err"},  32'(bus.mem_d_error_w),    32'h0);
    endtask

    task automatic run_burst(input string name, input int n);
        for (int c = 0; c < n + LAT + 1; c++) begin
            int j;
            if (c < n) drive(b_rd[c], b_wr[c], b_addr[c], b_wdata[c], b_tag[c], b_maint[c]);
            else       clr();
            @(negedge clk);
            chk($sformatf("%s.c%0d.accept", name, c), 32'(bus.mem_d_accept_w), 32'h1);
            j = c - LAT;
            if (j >= 0 && j < n) begin
                chk($sformatf("%s.r%0d.ack", name, j),  32'(bus.mem_d_ack_w),      32'h1);
                chk($sformatf("%s.r%0d.tag", name, j),  32'(bus.mem_d_resp_tag_w), 32'(b_tag[j]));
                chk($sformatf("%s.r%0d.data", name, j), bus.mem_d_data_rd_w,       e_data[j]);
                chk($sformatf("%s.r%0d.err", name, j),  32'(bus.mem_d_error_w),    32'(e_err[j]));
            end else begin
                expect_idle($sformatf("%s.c%0d.idle", name, c));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        rst = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.accept", 32'(bus.mem_d_accept_w), 32'h0);
        expect_idle("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("release.accept_before_edge", 32'(bus.mem_d_accept_w), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("release.accept_after_edge", 32'(bus.mem_d_accept_w), 32'h1);
        @(posedge clk); #1;

        // 1: full-word store then load of the same word
        slot(0, 1'b0, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 11'h005, 3'b000, 32'h0,         1'b0);
        slot(1, 1'b1, 4'h0, 32'h8000_0010, 32'h0,         11'h006, 3'b000, 32'hDEAD_BEEF, 1'b0);
        run_burst("t1", 2);

        // 2: byte-strobed store (bytes 0 and 2) then load
        slot(0, 1'b0, 4'b0101, 32'h8000_0010, 32'h1122_3344, 11'h007, 3'b000, 32'h0,         1'b0);
        slot(1, 1'b1, 4'h0,    32'h8000_0010, 32'h0,         11'h008, 3'b000, 32'hDE22_BE44, 1'b0);
        run_burst("t2", 2);

        // 3: error cases; word 0 seeded first so an aliased out-of-range store would show
        slot(0, 1'b0, 4'hF, 32'h8000_0000, 32'h1234_5678, 11'h010, 3'b000, 32'h0,         1'b0);
        slot(1, 1'b1, 4'h0, 32'h7FFF_FFFC, 32'h0,         11'h009, 3'b000, 32'h0,         1'b1);
        slot(2, 1'b0, 4'hF, 32'h8000_4000, 32'hFFFF_FFFF, 11'h00A, 3'b000, 32'h0,         1'b1);
        slot(3, 1'b1, 4'h0, 32'h8000_0002, 32'h0,         11'h00B, 3'b000, 32'h0,         1'b1);
        slot(4, 1'b1, 4'h0, 32'h8000_0000, 32'h0,         11'h00C, 3'b000, 32'h1234_5678, 1'b0);
        slot(5, 1'b1, 4'h3, 32'h8000_0000, 32'hAAAA_AAAA, 11'h00D, 3'b000, 32'h0,         1'b1);
        slot(6, 1'b1, 4'h0, 32'h8000_0000, 32'h0,         11'h00E, 3'b001, 32'h0,         1'b1);
        slot(7, 1'b1, 4'h0, 32'h8000_0000, 32'h0,         11'h00F, 3'b000, 32'h1234_5678, 1'b0);
        run_burst("t3", 8);

        // 4: four back-to-back loads, tags 1..4
        for (int i = 0; i < 4; i++)
            slot(i, 1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'(i + 1), 3'b000, 32'hDE22_BE44, 1'b0);
        run_burst("t4", 4);

        // 5: two loads in flight, then a one-cycle reset
        drive(1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h020, 3'b000);
        @(negedge clk);
        chk("t5.pre.ack0", 32'(bus.mem_d_ack_w), 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h021, 3'b000);
        @(negedge clk);
        chk("t5.pre.ack1", 32'(bus.mem_d_ack_w), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        @(negedge clk);
        chk("t5.inrst.accept", 32'(bus.mem_d_accept_w), 32'h0);
        expect_idle("t5.inrst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5.rel.accept", 32'(bus.mem_d_accept_w), 32'h0);
        expect_idle("t5.rel");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("t5.post%0d.accept", k), 32'(bus.mem_d_accept_w), 32'h1);
            expect_idle($sformatf("t5.post%0d", k));
        end
        @(posedge clk); #1;
        slot(0, 1'b1, 4'h0, 32'h8000_0010, 32'h0, 11'h022, 3'b000, 32'hDE22_BE44, 1'b0);
        run_burst("t5.load", 1);

        // 6: flush with max tag, other maintenance ops, then RAM still intact
        slot(0, 1'b0, 4'h0, 32'h8000_0010, 32'hFFFF_FFFF, 11'h7FF, 3'b001, 32'h0,         1'b0);
        slot(1, 1'b0, 4'h0, 32'h8000_0010, 32'h0,         11'h030, 3'b100, 32'h0,         1'b0);
        slot(2, 1'b0, 4'h0, 32'h9000_0000, 32'h0,         11'h031, 3'b010, 32'h0,         1'b0);
        slot(3, 1'b1, 4'h0, 32'h8000_0010, 32'h0,         11'h032, 3'b000, 32'hDE22_BE44, 1'b0);
        run_burst("t6", 4);

        // Last word of the RAM: in range, full store/load
        slot(0, 1'b0, 4'hF, 32'h8000_3FFC, 32'hCAFE_F00D, 11'h040, 3'b000, 32'h0,         1'b0);
        slot(1, 1'b1, 4'h0, 32'h8000_3FFC, 32'h0,         11'h041, 3'b000, 32'hCAFE_F00D, 1'b0);
        slot(2, 1'b1, 4'h0, 32'h8000_0000, 32'h0,         11'h042, 3'b000, 32'h1234_5678, 1'b0);
        run_burst("t7", 3);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
